// File: rtl/periph_timer_mc_pkg.sv
// Shared register map, TCON bit positions and timer-register selector for the
// memory-mapped timer/IO peripheral.
package periph_pkg;

   localparam logic [31:0] TIMER_STRIDE = 32'h10;

   localparam logic [3:0] OFF_TH   = 4'h0;
   localparam logic [3:0] OFF_TL   = 4'h4;
   localparam logic [3:0] OFF_TCON = 4'h8;

   localparam logic [31:0] OFF_LED     = 32'h100;
   localparam logic [31:0] OFF_SW      = 32'h104;
   localparam logic [31:0] OFF_DIGI    = 32'h108;
   localparam logic [31:0] OFF_IRQSTAT = 32'h10C;

   localparam int TCON_EN      = 0;
   localparam int TCON_IRQ_EN  = 1;
   localparam int TCON_PEND    = 2;
   localparam int TCON_ONESHOT = 3;

   typedef enum logic [1:0] {
      SEL_TH   = 2'd0,
      SEL_TL   = 2'd1,
      SEL_TCON = 2'd2,
      SEL_NONE = 2'd3
   } timer_sel_e;

   // Maps the low nibble of a timer-window offset to the register it names.
   function automatic timer_sel_e timer_sel(input logic [3:0] low);
      case (low)
         OFF_TH:   return SEL_TH;
         OFF_TL:   return SEL_TL;
         OFF_TCON: return SEL_TCON;
         default:  return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/periph_timer_mc_if.sv
// CPU data-bus view of the peripheral: strobes, address, write and read data.
interface periph_timer_mc_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/periph_timer_mc_timer_channel.sv
// One 32-bit reload timer: TH reload, TL count, TCON {oneshot,pend,irq_en,en}.
module timer_channel
   import periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   input  logic        pend_clr,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [3:0]  tcon,
   output logic        irq
);

   logic overflow;

   assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

   // CPU writes beat the counter; an overflow always sets pend, even against a clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (th_we) th <= wdata;

         if (tl_we)               tl <= wdata;
         else if (overflow)       tl <= th;
         else if (tcon[TCON_EN])  tl <= tl + 32'd1;

         if (tcon_we) begin
            tcon <= wdata[3:0];
            if (overflow) tcon[TCON_PEND] <= 1'b1;
         end else if (overflow) begin
            tcon[TCON_PEND] <= 1'b1;
            if (tcon[TCON_ONESHOT]) tcon[TCON_EN] <= 1'b0;
         end else if (pend_clr) begin
            tcon[TCON_PEND] <= 1'b0;
         end
      end
   end

   assign irq = tcon[TCON_PEND] & tcon[TCON_IRQ_EN];

endmodule

// File: rtl/periph_timer_mc.sv
// Peripheral top: address decode, read mux, timer array, LED/DIGI registers,
// switch synchroniser and combined interrupt.
module periph_timer_mc
   import periph_pkg::*;
#(
   parameter int          NUM_TIMERS = 2,
   parameter int          LED_W      = 8,
   parameter int          SW_W       = 8,
   parameter int          DIGI_W     = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
)(
   input  logic               clk,
   input  logic               reset,
   periph_timer_mc_if.slave   bus,
   output logic [LED_W-1:0]   led,
   input  logic [SW_W-1:0]    switch,
   output logic [DIGI_W-1:0]  digi,
   output logic               irqout
);

   logic [31:0]           off;
   logic                  timer_hit;
   logic [2:0]            timer_idx;
   timer_sel_e            sel;
   logic [NUM_TIMERS-1:0] th_we, tl_we, tcon_we, pend_clr, irq, pend_vec;
   logic [31:0]           th_q   [NUM_TIMERS];
   logic [31:0]           tl_q   [NUM_TIMERS];
   logic [3:0]            tcon_q [NUM_TIMERS];
   logic [SW_W-1:0]       sw_meta, sw_sync;
   logic [31:0]           rdata;

   assign off       = bus.addr - BASE_ADDR;
   assign timer_hit = (off[1:0] == 2'b00) && (off < (TIMER_STRIDE * 32'(NUM_TIMERS)));
   assign timer_idx = off[6:4];
   assign sel       = timer_sel(off[3:0]);

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
      logic hit;
      assign hit         = bus.wr && timer_hit && (timer_idx == 3'(i));
      assign th_we[i]    = hit && (sel == SEL_TH);
      assign tl_we[i]    = hit && (sel == SEL_TL);
      assign tcon_we[i]  = hit && (sel == SEL_TCON);
      assign pend_clr[i] = bus.wr && (off == OFF_IRQSTAT) && bus.wdata[i];
      assign pend_vec[i] = tcon_q[i][TCON_PEND];

      timer_channel u_timer (
         .clk      (clk),
         .reset    (reset),
         .th_we    (th_we[i]),
         .tl_we    (tl_we[i]),
         .tcon_we  (tcon_we[i]),
         .pend_clr (pend_clr[i]),
         .wdata    (bus.wdata),
         .th       (th_q[i]),
         .tl       (tl_q[i]),
         .tcon     (tcon_q[i]),
         .irq      (irq[i])
      );
   end

   // Switches are asynchronous; SW reads only ever see the second stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         led     <= '0;
         digi    <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switch;
         sw_sync <= sw_meta;
         if (bus.wr && (off == OFF_LED))  led  <= bus.wdata[LED_W-1:0];
         if (bus.wr && (off == OFF_DIGI)) digi <= bus.wdata[DIGI_W-1:0];
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.rd) begin
         if (timer_hit) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
               if (timer_idx == 3'(i)) begin
                  case (sel)
                     SEL_TH:   rdata = th_q[i];
                     SEL_TL:   rdata = tl_q[i];
                     SEL_TCON: rdata = {28'd0, tcon_q[i]};
                     default:  rdata = '0;
                  endcase
               end
            end
         end else begin
            case (off)
               OFF_LED:     rdata = 32'(led);
               OFF_SW:      rdata = 32'(sw_sync);
               OFF_DIGI:    rdata = 32'(digi);
               OFF_IRQSTAT: rdata = 32'(pend_vec);
               default:     rdata = '0;
            endcase
         end
      end
   end

   assign bus.rdata = rdata;
   assign irqout    = |irq;

endmodule

// File: tb/tb_periph_timer_mc.sv
// Randomised self-checking bench for periph_timer_mc against a behavioural
// register-map model, plus directed timer/collision/switch scenarios.
module tb_periph_timer_mc;

   localparam int          NT   = 2;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  switch;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   periph_timer_mc_if bus ();

   periph_timer_mc #(
      .NUM_TIMERS (NT),
      .LED_W      (8),
      .SW_W       (8),
      .DIGI_W     (12),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .led    (led),
      .switch (switch),
      .digi   (digi),
      .irqout (irqout)
   );

   always #5 clk = ~clk;

   // Reference model state: register contents as software would see them.
   logic [31:0] m_th [NT];
   logic [31:0] m_tl [NT];
   logic        m_en [NT];
   logic        m_ie [NT];
   logic        m_pend [NT];
   logic        m_os [NT];
   logic [7:0]  m_led, m_sw1, m_sw2;
   logic [11:0] m_digi;

   int         num_compared   = 0;
   int         num_mismatched = 0;
   bit         checks_on      = 0;
   logic [7:0] sw_cur         = 8'h00;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_compared++;
      if (got !== exp) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      logic [31:0] o;
      int          i;
      o = a - BASE;
      if (o[1:0] != 2'b00) return 32'h0;
      if (o < 32'(NT * 16)) begin
         i = int'(o[7:4]);
         case (o[3:0])
            4'h0:    return m_th[i];
            4'h4:    return m_tl[i];
            4'h8:    return {28'd0, m_os[i], m_pend[i], m_ie[i], m_en[i]};
            default: return 32'h0;
         endcase
      end
      if (o == 32'h100) return {24'd0, m_led};
      if (o == 32'h104) return {24'd0, m_sw2};
      if (o == 32'h108) return {20'd0, m_digi};
      if (o == 32'h10C) begin
         modelRead = 32'h0;
         for (int k = 0; k < NT; k++) modelRead[k] = m_pend[k];
         return modelRead;
      end
      return 32'h0;
   endfunction

   function automatic logic modelIrq();
      logic any = 1'b0;
      for (int k = 0; k < NT; k++) any |= m_pend[k] & m_ie[k];
      return any;
   endfunction

   // One clock edge: timers advance on their old values, then the CPU write lands.
   task automatic modelStep(input bit rst_n, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [7:0] sw);
      logic [31:0] o;
      bit          ovf;
      if (!rst_n) begin
         for (int k = 0; k < NT; k++) begin
            m_th[k] = 0; m_tl[k] = 0; m_en[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_os[k] = 0;
         end
         m_led = 0; m_digi = 0; m_sw1 = 0; m_sw2 = 0;
         return;
      end
      m_sw2 = m_sw1;
      m_sw1 = sw;
      o = a - BASE;
      for (int k = 0; k < NT; k++) begin
         logic [31:0] old_th = m_th[k];
         ovf = m_en[k] && (m_tl[k] == 32'hFFFF_FFFF);
         if (ovf) begin
            m_tl[k]   = old_th;
            m_pend[k] = 1'b1;
            if (m_os[k]) m_en[k] = 1'b0;
         end else if (m_en[k]) begin
            m_tl[k] = m_tl[k] + 32'd1;
         end
         if (w) begin
            if (o == 32'(k * 16))     m_th[k] = d;
            if (o == 32'(k * 16 + 4)) m_tl[k] = d;
            if (o == 32'(k * 16 + 8)) begin
               m_en[k] = d[0]; m_ie[k] = d[1]; m_pend[k] = d[2] | ovf; m_os[k] = d[3];
            end
            if (o == 32'h10C && d[k] && !ovf) m_pend[k] = 1'b0;
         end
      end
      if (w && o == 32'h100) m_led  = d[7:0];
      if (w && o == 32'h108) m_digi = d[11:0];
   endtask

   task automatic applyStimulus(input bit rst_n, input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [7:0] sw);
      reset     = rst_n;
      bus.rd    = r;
      bus.wr    = w;
      bus.addr  = a;
      bus.wdata = d;
      switch    = sw;
      #4;
      if (checks_on) begin
         checkOutput("rdata",  bus.rdata, r ? modelRead(a) : 32'h0);
         checkOutput("irqout", {31'd0, irqout}, {31'd0, modelIrq()});
         checkOutput("led",    {24'd0, led},  {24'd0, m_led});
         checkOutput("digi",   {20'd0, digi}, {20'd0, m_digi});
      end
      @(posedge clk);
      modelStep(rst_n, w, a, d, sw);
      #1;
   endtask

   task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.rd   = 1'b1;
      bus.wr   = 1'b0;
      bus.addr = a;
      #1;
      checkOutput(tag, bus.rdata, exp);
      bus.rd = 1'b0;
   endtask

   task automatic wrReg(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1'b1, 1'b0, 1'b1, a, d, sw_cur);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, sw_cur);
   endtask

   initial begin
      // Reset held two cycles while a LED write is attempted.
      applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h100, 32'hFF, 8'h00);
      checks_on = 1;
      applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h100, 32'hFF, 8'h00);
      checkOutput("reset_led", {24'd0, led}, 32'h0);
      checkOutput("reset_irq", {31'd0, irqout}, 32'h0);
      readCheck("reset_th0",  BASE + 32'h0,   32'h0);
      readCheck("reset_ledr", BASE + 32'h100, 32'h0);
      readCheck("reset_tcon1", BASE + 32'h18, 32'h0);

      // Periodic timer 0, IRQSTAT clear, set-wins and TCON collisions.
      wrReg(BASE + 32'h0, 32'hFFFF_FFFC);
      wrReg(BASE + 32'h4, 32'hFFFF_FFFC);
      wrReg(BASE + 32'h8, 32'h3);
      idle(3);
      checkOutput("periodic_pre",  {31'd0, irqout}, 32'h0);
      idle(1);
      checkOutput("periodic_rise", {31'd0, irqout}, 32'h1);
      readCheck("periodic_tl", BASE + 32'h4, 32'hFFFF_FFFC);
      wrReg(BASE + 32'h10C, 32'h1);
      checkOutput("irqstat_clear", {31'd0, irqout}, 32'h0);
      idle(2);
      wrReg(BASE + 32'h10C, 32'h1);
      readCheck("set_wins", BASE + 32'h10C, 32'h1);
      checkOutput("set_wins_irq", {31'd0, irqout}, 32'h1);
      idle(3);
      wrReg(BASE + 32'h8, 32'h3);
      readCheck("tcon_collide", BASE + 32'h8, 32'h7);
      wrReg(BASE + 32'h8, 32'h0);

      // One-shot timer 1.
      wrReg(BASE + 32'h10, 32'h0);
      wrReg(BASE + 32'h14, 32'hFFFF_FFFE);
      wrReg(BASE + 32'h18, 32'hB);
      idle(2);
      readCheck("oneshot_tcon", BASE + 32'h18, 32'hE);
      readCheck("oneshot_tl",   BASE + 32'h14, 32'h0);
      idle(3);
      readCheck("oneshot_hold", BASE + 32'h14, 32'h0);
      wrReg(BASE + 32'h10C, 32'h3);

      // LED/DIGI widths, switch synchroniser latency, unmapped window.
      wrReg(BASE + 32'h100, 32'h1234_56C3);
      readCheck("led_rd", BASE + 32'h100, 32'hC3);
      wrReg(BASE + 32'h108, 32'hFFFF_FABC);
      readCheck("digi_rd", BASE + 32'h108, 32'hABC);
      sw_cur = 8'hA5;
      idle(1);
      readCheck("sw_plus1", BASE + 32'h104, 32'h00);
      idle(1);
      readCheck("sw_plus2", BASE + 32'h104, 32'hA5);
      wrReg(BASE + 32'h1F0, 32'hFFFF_FFFF);
      readCheck("unmapped", BASE + 32'h1F0, 32'h0);
      readCheck("unmapped_led", BASE + 32'h100, 32'hC3);

      // Randomised traffic biased toward near-overflow counts.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a, d;
         int          k;
         k = int'($urandom_range(0, 11));
         case (k)
            0, 1, 2, 3, 4, 5:
               a = BASE + 32'($urandom_range(0, NT - 1) * 16) + 32'($urandom_range(0, 3) * 4);
            6:  a = BASE + 32'h100;
            7:  a = BASE + 32'h104;
            8:  a = BASE + 32'h108;
            9:  a = BASE + 32'h10C;
            10: a = BASE + 32'h110 + 32'($urandom_range(0, 60) * 4);
            default: a = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                           d = $urandom;
         if ($urandom_range(0, 19) == 0) sw_cur = 8'($urandom);
         applyStimulus(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), a, d, sw_cur);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/periph_timer_mc.md
# periph_timer_mc

Memory-mapped peripheral block on the CPU data bus. It provides `NUM_TIMERS` independent 32-bit reload timers with one-shot/periodic mode and a per-timer interrupt pending bit, a combined interrupt output, a parametrised LED register, a synchronised switch input and a 7-segment drive register. It sits beside data memory in the pipelined CPU and is selected by address. Reads are combinational; writes take effect on the next `clk` edge.

## Interface
- `NUM_TIMERS`, 2: timer channels, 1..8.
- `LED_W`, 8: LED register width, 1..32.
- `SW_W`, 8: switch input width, 1..32.
- `DIGI_W`, 12: 7-segment drive register width, 1..32.
- `BASE_ADDR`, 32'h40000000: base of the register window.

- `clk` input 1: single clock for the whole block.
- `reset` input 1: synchronous, active-low. Sampled only on the `clk` rising edge.
- `rd` input 1: read strobe.
- `wr` input 1: write strobe.
- `addr` input 32: byte address. It must be word-aligned.
- `wdata` input 32: write data.
- `rdata` output 32: read data. It is 0 when `rd`=0 or the address is unmapped.
- `led` output LED_W: LED register.
- `switch` input SW_W: asynchronous switch levels.
- `digi` output DIGI_W: 7-segment drive register.
- `irqout` output 1: OR of (pending & irq_en) over all timers.

## Operation
- Timer i registers are at `BASE_ADDR + 16*i`.
  - TH at +0x0: the reload value.
  - TL at +0x4: the count.
  - TCON at +0x8.
- TCON bits:
  - [0] `en`
  - [1] `irq_en`
  - [2] `pend`
  - [3] `oneshot`
  - [31:4] read as 0.
- Common registers:
  - `BASE_ADDR+0x100` LED: R/W, zero-extended on read.
  - `+0x104` SW: read-only. It returns the synchronised switch value.
  - `+0x108` DIGI: R/W.
  - `+0x10C` IRQSTAT: bit i = `pend` of timer i. Writing 1 to bit i clears that `pend`; writing 0 leaves it unchanged.
- Any other address reads 0. Writes to it are ignored.
- Counting: when `en`=1, TL increments by 1 each cycle.
- Overflow (TL==32'hFFFFFFFF while `en`=1):
  - TL loads TH.
  - `pend` is set to 1, regardless of `irq_en`.
  - If `oneshot`=1, `en` clears to 0.
- `pend` is set regardless of `irq_en`. Only `irqout` is gated by `irq_en`.
- TCON write: all four bits load from `wdata[3:0]`. Writing `pend`=1 through TCON is allowed and is used for software-triggered interrupts.
- Simultaneous events in the same cycle:
  - CPU write to TL together with overflow/increment: the write wins.
  - CPU write to TCON together with overflow: `en` and `oneshot` take the written values, and `pend` = written `pend` OR 1.
  - IRQSTAT clear together with overflow on the same timer: the set wins, so `pend` stays 1.
- Switch path: a 2-flop synchroniser per bit. SW reads return the second stage.
- Reset values (`reset`=0 at an edge):
  - TH, TL, TCON, `led`, `digi`, IRQSTAT all 0.
  - Both synchroniser stages 0.
  - `irqout` 0 from the cycle after the reset edge.
- Reset mid-count overrides everything, including a concurrent `wr`.

## Timing
- Read latency 0: `rdata` is a combinational function of `rd`, `addr` and the current registers.
- A write with `wr`=1 at edge N is visible on `rdata` and the outputs after edge N.
- From TL=32'hFFFFFFFE with `en`=1:
  - TL=32'hFFFFFFFF after 1 edge.
  - After the next edge, TL=TH, `pend`=1, and `irqout`=1 if `irq_en`=1.
- Timer period is `2^32 - TH` cycles.
- A switch change is visible in a SW read 2 edges after it settles.
- `irqout` is registered-derived, with no combinational path from bus inputs.

## Structure
- Package `periph_pkg`:
  - offset constants (TH/TL/TCON, LED, SW, DIGI, IRQSTAT)
  - TCON bit indices
  - the timer stride of 16
- Sub-module `timer_channel`, instantiated `NUM_TIMERS` times in a generate loop:
  - owns TH, TL and TCON
  - inputs: decoded write enables per register, `wdata`, `pend_clr`
  - outputs: TH, TL, TCON, and `irq` = `pend & irq_en`
- The top holds the address decode, read mux, LED/DIGI registers, synchroniser and IRQ OR.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset`=0 for 2 cycles with `wr`=1 writing LED=8'hFF.
  - Response: `led`=0, all reads return 0, `irqout`=0.
- Periodic timer 0:
  - Stimulus: TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, TCON=4'b0011.
  - Response: `irqout` rises 4 cycles after the TCON write edge, and TL reads 32'hFFFFFFFC.
  - Then write IRQSTAT=1: `irqout` falls the next cycle and rises again 4 cycles later.
- One-shot timer 1:
  - Stimulus: TH=0, TL=32'hFFFFFFFE, TCON=4'b1011.
  - Response: after 2 edges `pend`=1, `en`=0, TL=0, and TL stays 0 thereafter.
- Set-wins collision:
  - Stimulus: IRQSTAT write of 1 in the same cycle as a timer-0 overflow.
  - Response: `pend` reads 1.
- TCON collision:
  - Stimulus: TCON write 4'b0011 in the same cycle as an overflow.
  - Response: TCON reads 4'b0111.
- Switch and unmapped address:
  - Stimulus: `switch`=8'hA5 applied.
  - Response: SW read is still 8'h00 at +1 edge and is 8'hA5 at +2 edges.
  - A read at `BASE_ADDR+0x1F0` returns 0.
